// File: rtl/video_timing_pkg.sv
// Shared raster timing constants for the 15/31 kHz video timing generator.
package video_timing_pkg;

    // One complete raster description; *_end values are exclusive.
    typedef struct packed {
        logic [9:0] h_total;
        logic [9:0] h_active;
        logic [9:0] h_sync_start;
        logic [9:0] h_sync_end;
        logic [9:0] v_total;
        logic [9:0] v_active;
        logic [9:0] v_sync_start;
        logic [9:0] v_sync_end;
    } timing_t;

    localparam timing_t NTSC_TIMING = '{
        h_total:      10'd384,
        h_active:     10'd320,
        h_sync_start: 10'd336,
        h_sync_end:   10'd360,
        v_total:      10'd262,
        v_active:     10'd240,
        v_sync_start: 10'd244,
        v_sync_end:   10'd247
    };

    localparam timing_t PAL_TIMING = '{
        h_total:      10'd384,
        h_active:     10'd320,
        h_sync_start: 10'd336,
        h_sync_end:   10'd360,
        v_total:      10'd312,
        v_active:     10'd288,
        v_sync_start: 10'd292,
        v_sync_end:   10'd295
    };

endpackage

// File: rtl/video_ce_gen.sv
// Pixel clock-enable divider: one-clk ce every CE_DIV clks, or CE_DIV/2 when half=1.
module video_ce_gen #(
    parameter int CE_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic half,
    input  logic restart,
    output logic ce
);
    localparam int CW = $clog2(CE_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last;

    // Terminal count depends on the active pixel rate.
    always_comb begin
        last = half ? CW'(CE_DIV / 2 - 1) : CW'(CE_DIV - 1);
    end

    assign ce = (cnt_q == last);

    // Free-running count; restart forces phase 0 so a rate change never shortens a period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || ce) cnt_d = '0;
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Video raster timing generator: 384-pixel lines, NTSC/PAL frames, optional line doubling.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CE_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       frame_start
);
    // Mode latches, only updated at reset or at the frame boundary.
    logic       pal_q, pal_d;
    logic       sd_q, sd_d;
    // Position of the pixel the next ce will present (line_q counts output lines).
    logic [8:0] hpos_q, hpos_d;
    logic [9:0] line_q, line_d;
    // Registered outputs.
    logic       ce_pix_q, ce_pix_d;
    logic       fs_q, fs_d;
    logic       hblank_q, hblank_d;
    logic       hsync_q, hsync_d;
    logic       vblank_q, vblank_d;
    logic       vsync_q, vsync_d;
    logic [8:0] hcount_q, hcount_d;
    logic [8:0] vcount_q, vcount_d;

    logic       ce;
    logic       restart;
    timing_t    t;
    logic [9:0] last_line;
    logic [8:0] src_line;
    logic       h_wrap;
    logic       f_wrap;

    video_ce_gen #(.CE_DIV(CE_DIV)) u_ce (
        .clk     (clk),
        .reset   (reset),
        .half    (sd_q),
        .restart (restart),
        .ce      (ce)
    );

    // Decode the active raster and where the frame ends in output lines.
    always_comb begin
        t         = pal_q ? PAL_TIMING : NTSC_TIMING;
        last_line = sd_q ? ({t.v_total[8:0], 1'b0} - 10'd1) : (t.v_total - 10'd1);
        src_line  = sd_q ? line_q[9:1] : line_q[8:0];
        h_wrap    = ({1'b0, hpos_q} == (t.h_total - 10'd1));
        f_wrap    = h_wrap && (line_q == last_line);
        restart   = ce && f_wrap && (scandouble != sd_q);
    end

    // Advance position on ce, present the pixel's decoded timing, latch mode at frame wrap.
    always_comb begin
        pal_d    = pal_q;
        sd_d     = sd_q;
        hpos_d   = hpos_q;
        line_d   = line_q;
        ce_pix_d = ce;
        fs_d     = 1'b0;
        hblank_d = hblank_q;
        hsync_d  = hsync_q;
        vblank_d = vblank_q;
        vsync_d  = vsync_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (ce) begin
            hcount_d = hpos_q;
            vcount_d = src_line;
            hblank_d = ({1'b0, hpos_q} >= t.h_active);
            hsync_d  = ({1'b0, hpos_q} >= t.h_sync_start) && ({1'b0, hpos_q} < t.h_sync_end);
            vblank_d = ({1'b0, src_line} >= t.v_active);
            vsync_d  = ({1'b0, src_line} >= t.v_sync_start) && ({1'b0, src_line} < t.v_sync_end);
            fs_d     = (hpos_q == 9'd0) && (line_q == 10'd0);
            if (h_wrap) begin
                hpos_d = 9'd0;
                if (f_wrap) begin
                    line_d = 10'd0;
                    pal_d  = pal;
                    sd_d   = scandouble;
                end else begin
                    line_d = line_q + 10'd1;
                end
            end else begin
                hpos_d = hpos_q + 9'd1;
            end
        end
    end

    // State and output registers; reset overrides everything and samples the mode inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pal_q    <= pal;
            sd_q     <= scandouble;
            hpos_q   <= '0;
            line_q   <= '0;
            ce_pix_q <= 1'b0;
            fs_q     <= 1'b0;
            hblank_q <= 1'b0;
            hsync_q  <= 1'b0;
            vblank_q <= 1'b0;
            vsync_q  <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            pal_q    <= pal_d;
            sd_q     <= sd_d;
            hpos_q   <= hpos_d;
            line_q   <= line_d;
            ce_pix_q <= ce_pix_d;
            fs_q     <= fs_d;
            hblank_q <= hblank_d;
            hsync_q  <= hsync_d;
            vblank_q <= vblank_d;
            vsync_q  <= vsync_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign ce_pix      = ce_pix_q;
    assign frame_start = fs_q;
    assign HBlank      = hblank_q;
    assign HSync       = hsync_q;
    assign VBlank      = vblank_q;
    assign VSync       = vsync_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;

endmodule
